addsub_serial: RTL and testbench



---
 rtl/addsub_pkg.sv | 6 +
 rtl/addsub_chunk.sv | 25 ++
 rtl/addsub_serial.sv | 108 ++++++++++
 tb/tb_addsub_serial.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and mode constants for the serial adder/subtractor
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple adder that also exposes the carry into its MSB
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic c;
    // ripple the carry bit by bit, remembering the carry that enters the top bit
    always_comb begin
        c = cin;
        cmsb = 1'b0;
        sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) cmsb = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle WIDTH-bit add/sub, CHUNK bits per clock; ADDSUB_SAT_EN enables signed saturation
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CHUNK-1:0] sum;
    logic c_out, c_msb, last;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_q[cnt_q*CHUNK +: CHUNK]),
        .b    (b_q[cnt_q*CHUNK +: CHUNK]),
        .cin  (carry_q),
        .sum  (sum),
        .cout (c_out),
        .cmsb (c_msb)
    );

    assign last = cnt_q == CW'(NCHUNK - 1);
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy = state_q == BUSY;
    assign result = result_q;
    assign cout = cout_q;
    assign ovf = ovf_q;

    // next state: latch operands on accept, walk the chunks, hold the result until taken
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        carry_d = carry_q;
        cnt_d = cnt_q;
        result_d = result_q;
        cout_d = cout_q;
        ovf_d = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d = a;
                b_d = (mode == MODE_SUB) ? ~b : b;
                carry_d = mode == MODE_SUB;
                cnt_d = '0;
                state_d = BUSY;
            end
            BUSY: begin
                result_d[cnt_q*CHUNK +: CHUNK] = sum;
                carry_d = c_out;
                cnt_d = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    cout_d = c_out;
                    ovf_d = c_msb ^ c_out;
                    state_d = DONE;
`ifdef ADDSUB_SAT_EN
                    if (c_msb ^ c_out)
                        result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            carry_q <= 1'b0;
            cnt_q <= '0;
            result_q <= '0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            carry_q <= carry_d;
            cnt_q <= cnt_d;
            result_q <= result_d;
            cout_q <= cout_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: randomized and directed checks of addsub_serial against an arithmetic reference model
module tb_addsub_serial;
    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0, mode = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, cout, ovf, busy;
    logic [W-1:0] result;
    int total = 0, bad = 0;

    addsub_serial #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, result} from plain modular arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        logic [W:0] s;
        logic [W-1:0] yy, r;
        logic o;
        yy = m ? ~y : y;
        s = {1'b0, x} + {1'b0, yy} + (W+1)'(m);
        r = s[W-1:0];
        o = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
`ifdef ADDSUB_SAT_EN
        if (o) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {o, s[W], r};
    endfunction

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("timeout", 0, 1);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        logic [W+1:0] e;
        e = model(x, y, m);
        chk({tag, "_res"}, 32'(result), 32'(e[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
    endtask

    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        int n;
        a = x; b = y; mode = m; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        int n;
        start(x, y, m);
        chk({tag, "_busy"}, 32'(busy), 1);
        wait_out(n);
        chk({tag, "_lat"}, 32'(n), N);
        check_res(tag, x, y, m);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, 32'(in_ready), 1);
    endtask

    initial begin
        int n;
        logic [W-1:0] hold, x, y;
        logic m;
        logic seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ovf", 32'(ovf), 0);

        do_op("add", 16'h1234, 16'h0FFF, 1'b0);
        do_op("sub_borrow", 16'd5, 16'd7, 1'b1);
        do_op("sub_eq", 16'd8, 16'd8, 1'b1);
        do_op("sub_nb", 16'd8, 16'd2, 1'b1);
        do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0);
        do_op("ovf_sub", 16'h8000, 16'h0001, 1'b1);
        do_op("max_add", 16'hFFFF, 16'hFFFF, 1'b0);

        start(16'h4321, 16'h1111, 1'b0);
        wait_out(n);
        hold = result;
        check_res("bp", 16'h4321, 16'h1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("bp_stable", 32'(result), 32'(hold));
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", 32'(in_ready), 1);
        chk("bp_release_ov", 32'(out_valid), 0);
        do_op("bp_next", 16'h0F0F, 16'h00F1, 1'b1);

        start(16'h7000, 16'h7000, 1'b0);
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmid_in_ready", 32'(in_ready), 1);
        chk("rmid_busy", 32'(busy), 0);
        for (int i = 0; i < N + 2; i++) begin
            seen |= out_valid;
            @(negedge clk);
        end
        chk("rmid_no_pulse", 32'(seen), 0);
        do_op("rmid_after", 16'h0001, 16'h0001, 1'b0);

        out_ready = 1'b1;
        start(16'hA5A5, 16'h5A5A, 1'b0);
        a = 16'h1000; b = 16'h2000; mode = 1'b1; in_valid = 1'b1;
        wait_out(n);
        check_res("b2b1", 16'hA5A5, 16'h5A5A, 1'b0);
        @(negedge clk);
        chk("b2b_idle", 32'(in_ready), 1);
        @(negedge clk);
        chk("b2b_accepted", 32'(busy), 1);
        in_valid = 1'b0;
        wait_out(n);
        chk("b2b_lat", 32'(n), N);
        check_res("b2b2", 16'h1000, 16'h2000, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            x = W'($urandom); y = W'($urandom); m = 1'($urandom);
            if (i % 8 == 0) x = {1'b0, {(W-1){1'b1}}};
            if (i % 8 == 1) x = {1'b1, {(W-1){1'b0}}};
            do_op("rand", x, y, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
